// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and helpers for the req/ack data synchroniser
package cdc_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    localparam int DEFAULT_STAGES = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop single-bit synchroniser with synchronous active-low reset
module sync_bit
    import cdc_pkg::*;
#(
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] ff_q;

    // shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk) ff_q <= !rstn ? '0 : {ff_q[STAGES-2:0], d_i};

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// data_sync_tx: source-side req/ack handshake transmitter with ack watchdog
module data_sync_tx
    import cdc_pkg::*;
#(
    parameter int STAGES  = DEFAULT_STAGES,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DWIDTH-1:0] tx_data,
    output logic              tx_req,
    input  logic              ack_i,
    output logic              done,
    output logic              err,
    input  logic              err_clr
);

    // counter holds 0..TIMEOUT so it can rest one past the trip value and fire err once
    localparam int            CW   = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              req_q, req_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ack_s;

    sync_bit #(.STAGES(STAGES)) u_ack_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (ack_i),
        .q_o  (ack_s)
    );

    // handshake sequencing, data capture and watchdog next-state
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        rdy_d   = rdy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q & ~err_clr;
        case (state_q)
            IDLE: if (s_valid) begin
                data_d  = s_data;
                req_d   = 1'b1;
                rdy_d   = 1'b0;
                cnt_d   = '0;
                state_d = REQ;
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end
                if (TIMEOUT > 0) begin
                    cnt_d = (cnt_q == TOP) ? cnt_q : cnt_q + CW'(1);
                    if (cnt_q == LAST && !ack_s) err_d = 1'b1;
                end
            end
            RELEASE: if (!ack_s) begin
                rdy_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // register all state and outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_ready = rdy_q;
    assign tx_data = data_q;
    assign tx_req  = req_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// tb_data_sync_tx: directed checks plus a receiver model with a data scoreboard
module tb_data_sync_tx;

    logic       clk = 1'b0, rclk = 1'b0, rstn = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0, err_clr = 1'b0;
    logic       s_ready, tx_req, ack_i, done, err;
    logic [7:0] tx_data;
    logic       man_ack = 1'b0, use_rx = 1'b0;
    logic       rx_ack = 1'b0, rq1 = 1'b0, rq2 = 1'b0;
    logic       prev_req = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         total = 0, bad = 0, done_cnt = 0, stab_bad = 0;

    always #3 clk = ~clk;
    always #7 rclk = ~rclk;

    assign ack_i = use_rx ? rx_ack : man_ack;

    data_sync_tx #(.STAGES(2), .DWIDTH(8), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .ack_i   (ack_i),
        .done    (done),
        .err     (err),
        .err_clr (err_clr)
    );

    // behavioural receiver: two-flop request sync, capture on new request, 4-phase ack
    always @(posedge rclk) begin
        rq1 <= tx_req;
        rq2 <= rq1;
        if (!rq2) rx_ack <= 1'b0;
        else if (use_rx && !rx_ack) begin
            rx_ack <= 1'b1;
            got_q.push_back(tx_data);
        end
    end

    // monitor: tx_data stability while requesting, and done pulse count
    always @(negedge clk) begin
        if (tx_req && prev_req && tx_data !== prev_data) stab_bad <= stab_bad + 1;
        prev_req  <= tx_req;
        prev_data <= tx_data;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [7:0] words [3];
        int         idx, n, base;
        words = '{8'h01, 8'h02, 8'h03};

        // reset with ack held high
        man_ack = 1'b1;
        repeat (3) tick();
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_tx_req",  {31'd0, tx_req},  32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_err",     {31'd0, err},     32'd0);
        check("rst_done",    {31'd0, done},    32'd0);
        rstn = 1'b1;
        man_ack = 1'b0;
        repeat (5) tick();
        check("idle_no_req",   {31'd0, tx_req},  32'd0);
        check("idle_s_ready",  {31'd0, s_ready}, 32'd1);
        check("idle_no_done",  done_cnt,         32'd0);

        // single transfer with exact latencies, plus ignored input during REQ
        s_data = 8'hA5; s_valid = 1'b1;
        tick(); s_valid = 1'b0;
        check("c1_tx_req",  {31'd0, tx_req},  32'd1);
        check("c1_tx_data", {24'd0, tx_data}, 32'hA5);
        check("c1_s_ready", {31'd0, s_ready}, 32'd0);
        tick(); s_data = 8'hFF; s_valid = 1'b1;
        tick(); s_valid = 1'b0;
        tick();
        check("ignored_data", {24'd0, tx_data}, 32'hA5);
        tick(); man_ack = 1'b1;
        tick(); tick();
        check("c7_tx_req_hi", {31'd0, tx_req}, 32'd1);
        tick();
        check("c8_tx_req_lo", {31'd0, tx_req},  32'd0);
        check("c8_s_ready",   {31'd0, s_ready}, 32'd0);
        tick(); tick(); man_ack = 1'b0;
        tick(); tick();
        check("c12_done_lo",  {31'd0, done},    32'd0);
        check("c12_s_ready",  {31'd0, s_ready}, 32'd0);
        tick();
        check("c13_done",     {31'd0, done},    32'd1);
        check("c13_s_ready",  {31'd0, s_ready}, 32'd1);
        check("c13_hold",     {24'd0, tx_data}, 32'hA5);
        tick();
        check("c14_done_lo",  {31'd0, done},    32'd0);
        check("single_dones", done_cnt,         32'd1);

        // watchdog with ack stuck low
        s_data = 8'h5A; s_valid = 1'b1;
        tick(); s_valid = 1'b0;
        check("wd_req", {31'd0, tx_req}, 32'd1);
        repeat (15) tick();
        check("wd_c16_err", {31'd0, err}, 32'd0);
        tick();
        check("wd_c17_err", {31'd0, err},    32'd1);
        check("wd_in_req",  {31'd0, tx_req}, 32'd1);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        check("wd_clr", {31'd0, err}, 32'd0);
        repeat (5) tick();
        check("wd_no_reset", {31'd0, err}, 32'd0);
        man_ack = 1'b1;
        n = 0;
        while (tx_req !== 1'b0 && n < 50) begin tick(); n++; end
        check("wd_late_ack", {31'd0, tx_req}, 32'd0);
        man_ack = 1'b0;
        wait_done("wd_done");
        check("wd_data", {24'd0, tx_data}, 32'h5A);

        // back-to-back through the receiver model
        tick();
        use_rx = 1'b1;
        base = done_cnt;
        foreach (words[i]) exp_q.push_back(words[i]);
        idx = 0; s_data = words[0]; s_valid = 1'b1;
        n = 0;
        while (idx < 3 && n < 600) begin
            if (s_ready) begin
                tick();
                idx++;
                if (idx < 3) s_data = words[idx];
                else s_valid = 1'b0;
            end else tick();
            n++;
        end
        s_valid = 1'b0;
        check("b2b_accepts", idx, 32'd3);
        n = 0;
        while (done_cnt - base < 3 && n < 600) begin tick(); n++; end
        repeat (20) tick();
        check("b2b_dones", done_cnt - base, 32'd3);
        check("b2b_got_n", got_q.size(), 32'd3);
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("b2b_word", {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        check("b2b_stable", stab_bad, 32'd0);
        exp_q.delete();
        got_q.delete();
        use_rx = 1'b0;

        // reset in the middle of a handshake
        s_data = 8'h77; s_valid = 1'b1;
        tick(); s_valid = 1'b0;
        check("mid_req", {31'd0, tx_req}, 32'd1);
        rstn = 1'b0;
        tick();
        check("mid_req_drop", {31'd0, tx_req},  32'd0);
        check("mid_s_ready",  {31'd0, s_ready}, 32'd1);
        rstn = 1'b1;
        repeat (10) tick();
        use_rx = 1'b1;
        exp_q.push_back(8'h3C);
        s_data = 8'h3C; s_valid = 1'b1;
        tick(); s_valid = 1'b0;
        wait_done("post_rst_done");
        check("post_rst_got_n", got_q.size(), 32'd1);
        if (got_q.size() > 0)
            check("post_rst_word", {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        check("post_rst_data", {24'd0, tx_data}, 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
